bus_arbiter_mux: RTL

- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC source words onto a WIDTH-bit shared bus.
- Arbitration is fixed-priority or round-robin, with an optional grant lock for multi-cycle transfers.
- Flags and counts simultaneous-driver conflicts, which the combinational bus silently resolves.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

---
 rtl/bus_arbiter_mux_if.sv | 28 ++
 rtl/bus_arbiter_mux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux_if.sv
// Shared-bus bundle: source words and drive requests in, registered bus and
// arbitration status out. The arbiter takes the slave side.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_req;
  logic                  lock;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  conflict;
  logic [CNT_W-1:0]      conflict_cnt;

  modport master (
    output src_data, src_req, lock,
    input  bus_out, bus_valid, grant, grant_idx, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, src_req, lock,
    output bus_out, bus_valid, grant, grant_idx, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with fixed-priority or round-robin arbitration,
// optional grant lock, and saturating count of multi-driver cycles.
module bus_arbiter_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int IDX_W = 5,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             clr,
  bus_arbiter_mux_if.slave bus
);

  logic [WIDTH-1:0] src_w [NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign src_w[i] = bus.src_data[i*WIDTH +: WIDTH];
  end

  function automatic logic multi_req(input logic [NSRC-1:0] req);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return multi;
  endfunction

  function automatic logic [IDX_W-1:0] fixed_pick(input logic [NSRC-1:0] req);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) w = IDX_W'(i);
    end
    return w;
  endfunction

  // Search begins just after the previous winner, so it is visited last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NSRC-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] w;
    logic             found;
    int               c;
    w     = last;
    found = 1'b0;
    for (int off = 1; off <= NSRC; off++) begin
      c = int'(last) + off;
      if (c >= NSRC) c = c - NSRC;
      if (!found && req[c]) begin
        w     = IDX_W'(c);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] bus_p0,   bus_nxt;
  logic             vld_p0,   vld_nxt;
  logic [NSRC-1:0]  grant_p0, grant_nxt;
  logic [IDX_W-1:0] idx_p0,   idx_nxt;
  logic             conf_p0,  conf_nxt;
  logic [CNT_W-1:0] cnt_p0,   cnt_nxt;

  logic             hold;
  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] win;

  always_comb begin
    hold      = bus.lock & vld_p0 & bus.src_req[idx_p0];
    any_req   = |bus.src_req;
    pick      = (MODE == 1) ? rr_pick(bus.src_req, idx_p0) : fixed_pick(bus.src_req);
    win       = hold ? idx_p0 : pick;

    idx_nxt   = idx_p0;
    vld_nxt   = 1'b0;
    bus_nxt   = '0;
    grant_nxt = '0;

    // A held grant reloads its source each cycle so data follows the holder.
    if (hold || any_req) begin
      idx_nxt   = win;
      vld_nxt   = 1'b1;
      bus_nxt   = src_w[win];
      grant_nxt = NSRC'(1) << win;
    end

    conf_nxt = multi_req(bus.src_req);
    cnt_nxt  = conf_nxt ? sat_inc(cnt_p0) : cnt_p0;
  end

  // Stage p0: single register stage, nothing combinational reaches the outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus_p0   <= '0;
      vld_p0   <= 1'b0;
      grant_p0 <= '0;
      idx_p0   <= IDX_W'(NSRC - 1);
      conf_p0  <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      bus_p0   <= bus_nxt;
      vld_p0   <= vld_nxt;
      grant_p0 <= grant_nxt;
      idx_p0   <= idx_nxt;
      conf_p0  <= conf_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign bus.bus_out      = bus_p0;
  assign bus.bus_valid    = vld_p0;
  assign bus.grant        = grant_p0;
  assign bus.grant_idx    = idx_p0;
  assign bus.conflict     = conf_p0;
  assign bus.conflict_cnt = cnt_p0;

endmodule
